// File: rtl/mp64_clkgate_ctrl.sv
// Clock-gate enable controller for one gated domain.
// Idle detection, sleep handshake, and timed wake in the always-on domain.
module mp64_clkgate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int DRAIN_MAX   = 64,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        busy,
    input  logic        wake_req,
    input  logic        force_on,
    input  logic        sleep_ack,
    output logic        clk_en,
    output logic        sleep_req,
    output logic        awake,
    output logic        wake_done,
    output logic        drain_timeout,
    output logic [15:0] gate_count
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_GATED,
        ST_WAKE
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_clk_en;
    logic               r_sleep_req;
    logic               r_awake;
    logic               r_wake_done;
    logic               r_drain_timeout;
    logic [15:0]        r_gate_count;

    logic               w_hold;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_hold    = busy | wake_req | force_on;
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_RUN;
            r_cnt           <= '0;
            r_clk_en        <= 1'b1;
            r_sleep_req     <= 1'b0;
            r_awake         <= 1'b1;
            r_wake_done     <= 1'b0;
            r_drain_timeout <= 1'b0;
            r_gate_count    <= 16'd0;
        end else begin
            r_wake_done     <= 1'b0;
            r_drain_timeout <= 1'b0;
            unique case (r_state)
                ST_RUN: begin
                    if (w_hold) begin
                        r_cnt <= '0;
                    end else if (r_cnt == IDLE_LAST) begin
                        r_state     <= ST_DRAIN;
                        r_cnt       <= '0;
                        r_sleep_req <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                // Any hold aborts the drain, even alongside sleep_ack.
                ST_DRAIN: begin
                    if (w_hold) begin
                        r_state     <= ST_RUN;
                        r_cnt       <= '0;
                        r_sleep_req <= 1'b0;
                    end else if (sleep_ack) begin
                        r_state  <= ST_GATED;
                        r_cnt    <= '0;
                        r_clk_en <= 1'b0;
                        r_awake  <= 1'b0;
                        if (r_gate_count != 16'hFFFF) begin
                            r_gate_count <= r_gate_count + 16'd1;
                        end
                    end else if (r_cnt == DRAIN_LAST) begin
                        r_state         <= ST_RUN;
                        r_cnt           <= '0;
                        r_sleep_req     <= 1'b0;
                        r_drain_timeout <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_GATED: begin
                    if (wake_req || force_on) begin
                        r_state     <= ST_WAKE;
                        r_cnt       <= '0;
                        r_clk_en    <= 1'b1;
                        r_sleep_req <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    if (r_cnt == WAKE_LAST) begin
                        r_state     <= ST_RUN;
                        r_cnt       <= '0;
                        r_awake     <= 1'b1;
                        r_wake_done <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_cnt       <= '0;
                    r_clk_en    <= 1'b1;
                    r_sleep_req <= 1'b0;
                    r_awake     <= 1'b1;
                end
            endcase
        end
    end

    assign clk_en        = r_clk_en;
    assign sleep_req     = r_sleep_req;
    assign awake         = r_awake;
    assign wake_done     = r_wake_done;
    assign drain_timeout = r_drain_timeout;
    assign gate_count    = r_gate_count;

endmodule

// File: tb/tb_mp64_clkgate_ctrl.sv
// Directed bench for mp64_clkgate_ctrl with default parameters.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_mp64_clkgate_ctrl;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic        wake_req;
    logic        force_on;
    logic        sleep_ack;
    logic        clk_en;
    logic        sleep_req;
    logic        awake;
    logic        wake_done;
    logic        drain_timeout;
    logic [15:0] gate_count;

    int checks = 0;
    int errors = 0;

    mp64_clkgate_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .busy          (busy),
        .wake_req      (wake_req),
        .force_on      (force_on),
        .sleep_ack     (sleep_ack),
        .clk_en        (clk_en),
        .sleep_req     (sleep_req),
        .awake         (awake),
        .wake_done     (wake_done),
        .drain_timeout (drain_timeout),
        .gate_count    (gate_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        busy      = 1'b0;
        wake_req  = 1'b0;
        force_on  = 1'b0;
        sleep_ack = 1'b0;
        tick(2);
        chk("rst_clk_en", 32'(clk_en), 32'd1);
        chk("rst_sleep_req", 32'(sleep_req), 32'd0);
        chk("rst_awake", 32'(awake), 32'd1);
        chk("rst_wake_done", 32'(wake_done), 32'd0);
        chk("rst_drain_to", 32'(drain_timeout), 32'd0);
        chk("rst_gate_count", 32'(gate_count), 32'd0);
        rst_n = 1'b1;

        // Plan 1: idle from reset, sleep on the 16th edge
        tick(15);
        chk("t1_no_sleep_15", 32'(sleep_req), 32'd0);
        tick(1);
        chk("t1_sleep_16", 32'(sleep_req), 32'd1);
        chk("t1_drain_clk_en", 32'(clk_en), 32'd1);
        chk("t1_drain_awake", 32'(awake), 32'd1);
        sleep_ack = 1'b1;
        tick(1);
        sleep_ack = 1'b0;
        chk("t1_gated_clk_en", 32'(clk_en), 32'd0);
        chk("t1_gated_awake", 32'(awake), 32'd0);
        chk("t1_gated_sleep", 32'(sleep_req), 32'd1);
        chk("t1_gate_count", 32'(gate_count), 32'd1);

        // Plan 2: one-cycle wake pulse
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        chk("t2_wake_clk_en", 32'(clk_en), 32'd1);
        chk("t2_wake_sleep", 32'(sleep_req), 32'd0);
        chk("t2_wake_awake0", 32'(awake), 32'd0);
        tick(1);
        chk("t2_wake_awake1", 32'(awake), 32'd0);
        chk("t2_wake_done_early", 32'(wake_done), 32'd0);
        tick(1);
        chk("t2_awake", 32'(awake), 32'd1);
        chk("t2_wake_done", 32'(wake_done), 32'd1);
        tick(1);
        chk("t2_wake_done_drop", 32'(wake_done), 32'd0);
        tick(14);
        chk("t2_no_sleep", 32'(sleep_req), 32'd0);
        tick(1);
        chk("t2_sleep", 32'(sleep_req), 32'd1);
        sleep_ack = 1'b1;
        tick(1);
        sleep_ack = 1'b0;
        chk("t2_gate_count", 32'(gate_count), 32'd2);
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        tick(2);
        chk("t2_rewake_awake", 32'(awake), 32'd1);

        // Plan 3: busy blip restarts idle count
        tick(10);
        busy = 1'b1;
        tick(1);
        busy = 1'b0;
        tick(6);
        chk("t3_no_sleep_6", 32'(sleep_req), 32'd0);
        tick(9);
        chk("t3_no_sleep_15", 32'(sleep_req), 32'd0);
        tick(1);
        chk("t3_sleep_16", 32'(sleep_req), 32'd1);

        // Plan 4: hold beats sleep_ack in DRAIN
        sleep_ack = 1'b1;
        wake_req  = 1'b1;
        tick(1);
        sleep_ack = 1'b0;
        wake_req  = 1'b0;
        chk("t4_sleep_req", 32'(sleep_req), 32'd0);
        chk("t4_clk_en", 32'(clk_en), 32'd1);
        chk("t4_awake", 32'(awake), 32'd1);
        chk("t4_gate_count", 32'(gate_count), 32'd2);

        // Plan 5: drain timeout after 64 cycles
        tick(16);
        chk("t5_sleep", 32'(sleep_req), 32'd1);
        tick(63);
        chk("t5_no_to_63", 32'(drain_timeout), 32'd0);
        chk("t5_still_drain", 32'(sleep_req), 32'd1);
        tick(1);
        chk("t5_timeout", 32'(drain_timeout), 32'd1);
        chk("t5_sleep_drop", 32'(sleep_req), 32'd0);
        chk("t5_gate_count", 32'(gate_count), 32'd2);
        tick(1);
        chk("t5_to_pulse", 32'(drain_timeout), 32'd0);
        tick(14);
        chk("t5_no_sleep", 32'(sleep_req), 32'd0);
        tick(1);
        chk("t5_resleep", 32'(sleep_req), 32'd1);

        // Plan 6: busy ignored while gated, force_on wakes and holds
        sleep_ack = 1'b1;
        tick(1);
        sleep_ack = 1'b0;
        chk("t6_gate_count", 32'(gate_count), 32'd3);
        busy = 1'b1;
        tick(1);
        busy = 1'b0;
        tick(1);
        busy = 1'b1;
        tick(1);
        chk("t6_busy_clk_en", 32'(clk_en), 32'd0);
        chk("t6_busy_awake", 32'(awake), 32'd0);
        busy     = 1'b0;
        force_on = 1'b1;
        tick(1);
        chk("t6_force_clk_en", 32'(clk_en), 32'd1);
        chk("t6_force_awake0", 32'(awake), 32'd0);
        tick(2);
        chk("t6_force_awake", 32'(awake), 32'd1);
        chk("t6_force_done", 32'(wake_done), 32'd1);
        tick(200);
        chk("t6_held_sleep", 32'(sleep_req), 32'd0);
        chk("t6_held_clk_en", 32'(clk_en), 32'd1);
        force_on = 1'b0;
        tick(16);
        chk("t6_sleep", 32'(sleep_req), 32'd1);
        sleep_ack = 1'b1;
        tick(1);
        sleep_ack = 1'b0;
        chk("t6_gate_count4", 32'(gate_count), 32'd4);
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        chk("t6_in_wake", 32'(awake), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_clk_en", 32'(clk_en), 32'd1);
        chk("t6_rst_awake", 32'(awake), 32'd1);
        chk("t6_rst_sleep", 32'(sleep_req), 32'd0);
        chk("t6_rst_gate_count", 32'(gate_count), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(15);
        chk("t6_post_rst_idle", 32'(sleep_req), 32'd0);
        tick(1);
        chk("t6_post_rst_sleep", 32'(sleep_req), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
